// File: rtl/norm_pkg.sv
// -----------------------------------------------------------------------------
// norm_pkg
// Shared types and constants for the fixed-point normalizer.
//   NORM_WIDTH   : index of the data MSB (data words are NORM_WIDTH+1 bits)
//   norm_t       : signed two's-complement data word
//   norm_shift_t : redundant-sign count / shift amount (0..NORM_WIDTH)
// -----------------------------------------------------------------------------
package norm_pkg;

  localparam int NORM_WIDTH = 15;
  localparam int NORM_SHIFT_WIDTH = $clog2(NORM_WIDTH + 1);

  typedef logic signed [NORM_WIDTH:0]       norm_t;
  typedef logic [NORM_SHIFT_WIDTH-1:0]      norm_shift_t;

endpackage : norm_pkg

// File: rtl/norm_lsc.sv
// -----------------------------------------------------------------------------
// norm_lsc
// Combinational leading-sign-bit counter. Counts how many consecutive bits
// below the sign bit are copies of the sign bit (redundant sign bits).
// Ports:
//   A   in  NORM_WIDTH+1  signed data word
//   lsc out SHW           redundant-sign count, 0..NORM_WIDTH
// -----------------------------------------------------------------------------
module norm_lsc #(
  parameter int NORM_WIDTH = norm_pkg::NORM_WIDTH,
  parameter int SHW        = $clog2(NORM_WIDTH + 1)
) (
  input  logic [NORM_WIDTH:0] A,
  output logic [SHW-1:0]      lsc
);

  // After XOR with the sign, redundant sign bits become zeros, so the count
  // is simply the number of leading zeros in the magnitude field.
  logic [NORM_WIDTH-1:0] diff;
  logic                  found;

  assign diff = A[NORM_WIDTH-1:0] ^ {NORM_WIDTH{A[NORM_WIDTH]}};

  // Priority encoder: the highest set bit of diff determines the count.
  // With no bit set (A == 0 or A == -1) every bit is redundant.
  always_comb begin
    lsc   = SHW'(NORM_WIDTH);
    found = 1'b0;
    for (int i = NORM_WIDTH - 1; i >= 0; i--) begin
      if (!found && diff[i]) begin
        lsc   = SHW'(NORM_WIDTH - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule : norm_lsc

// File: rtl/normalizer.sv
// -----------------------------------------------------------------------------
// normalizer
// Single-cycle registered normalizer: shifts a signed sample left by its
// redundant-sign count so the result's sign bit differs from the next bit.
// Ports:
//   A     in  NORM_WIDTH+1  signed input sample
//   out   out NORM_WIDTH+1  normalized result, registered (1-cycle latency)
//   clk   in  1             rising-edge clock
//   reset in  1             synchronous active-high reset, clears out
// -----------------------------------------------------------------------------
module normalizer #(
  parameter int NORM_WIDTH = norm_pkg::NORM_WIDTH
) (
  input  logic [NORM_WIDTH:0] A,
  output logic [NORM_WIDTH:0] out,
  input  logic                clk,
  input  logic                reset
);

  import norm_pkg::*;

  localparam int SHW = $clog2(NORM_WIDTH + 1);

  logic [SHW-1:0]        lsc;
  logic [NORM_WIDTH:0]   stage [SHW+1];
  logic [NORM_WIDTH:0]   out_next;

  norm_lsc #(
    .NORM_WIDTH (NORM_WIDTH),
    .SHW        (SHW)
  ) u_lsc (
    .A   (A),
    .lsc (lsc)
  );

  // Logarithmic barrel shifter: stage gi conditionally shifts by 2**gi.
  // Zero fill is correct because the shift never exceeds the number of
  // redundant sign bits, so no significant bit is lost.
  assign stage[0] = A;

  for (genvar gi = 0; gi < SHW; gi++) begin : g_shift
    assign stage[gi+1] = lsc[gi] ? (stage[gi] << (2 ** gi)) : stage[gi];
  end

  assign out_next = stage[SHW];

  // Reset takes priority so an unknown A during reset never reaches out.
  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
    end else begin
      out <= out_next;
    end
  end

endmodule : normalizer

// File: tb/tb_normalizer.sv
// -----------------------------------------------------------------------------
// tb_normalizer
// Directed and random self-checking bench for the normalizer.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_normalizer;
  import norm_pkg::*;

  logic  clk;
  logic  reset;
  norm_t a;
  norm_t y;

  int n_checks;
  int n_fail;

  normalizer #(.NORM_WIDTH(NORM_WIDTH)) dut (
    .A     (a),
    .out   (y),
    .clk   (clk),
    .reset (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: keep shifting left while the top two bits agree.
  function automatic norm_t norm_ref(input norm_t v);
    norm_t r;
    int    n;
    r = v;
    n = 0;
    while (r[NORM_WIDTH] == r[NORM_WIDTH-1] && n < NORM_WIDTH) begin
      r = r << 1;
      n++;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a     = 'x;
    tick();
    n_checks++;
    if (y !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_state: out=%h expected=%h", y, 16'h0000);
    end else
      $display("reset_state: A=x out=%h", y);
  endtask

  task automatic test_basic();
    reset = 1'b0;
    a     = 16'sd234;
    tick();
    n_checks++;
    if (y !== 16'h7500) begin
      n_fail++;
      $display("FAIL basic_234: out=%h expected=%h", y, 16'h7500);
    end else
      $display("basic_234: A=%h out=%h", a, y);
  endtask

  task automatic test_hold();
    a = -16'sd192;
    for (int i = 0; i < 11; i++) begin
      tick();
      n_checks++;
      if (y !== 16'hA000) begin
        n_fail++;
        $display("FAIL hold_neg192[%0d]: out=%h expected=%h", i, y, 16'hA000);
      end else
        $display("hold_neg192[%0d]: A=%h out=%h", i, a, y);
    end
  endtask

  task automatic test_corners();
    norm_t vin [6];
    norm_t vexp[6];
    norm_t prev;
    vin[0] = 16'h0000; vexp[0] = 16'h0000;
    vin[1] = 16'h0001; vexp[1] = 16'h4000;
    vin[2] = 16'hFFFF; vexp[2] = 16'h8000;
    vin[3] = 16'hFFFE; vexp[3] = 16'h8000;
    vin[4] = 16'h7FFF; vexp[4] = 16'h7FFF;
    vin[5] = 16'h8000; vexp[5] = 16'h8000;
    prev = 16'hA000;
    for (int i = 0; i < 6; i++) begin
      a = vin[i];
      #1;
      // New input must not show before the capturing edge.
      n_checks++;
      if (y !== prev) begin
        n_fail++;
        $display("FAIL corner_latency[%0d]: out=%h expected=%h", i, y, prev);
      end
      tick();
      n_checks++;
      if (y !== vexp[i]) begin
        n_fail++;
        $display("FAIL corner[%0d]: A=%h out=%h expected=%h", i, vin[i], y, vexp[i]);
      end else
        $display("corner[%0d]: A=%h out=%h", i, vin[i], y);
      prev = vexp[i];
    end
  endtask

  task automatic test_reset_midstream();
    a     = 16'h0003;
    reset = 1'b1;
    tick();
    n_checks++;
    if (y !== 16'h0000) begin
      n_fail++;
      $display("FAIL midreset: out=%h expected=%h", y, 16'h0000);
    end else
      $display("midreset: A=%h out=%h", a, y);
    reset = 1'b0;
    a     = 16'h0000;
    tick();
    n_checks++;
    if (y !== 16'h0000) begin
      n_fail++;
      $display("FAIL midreset_after: out=%h expected=%h", y, 16'h0000);
    end else
      $display("midreset_after: A=%h out=%h", a, y);
  endtask

  task automatic test_random();
    norm_t exp_v;
    for (int i = 0; i < 10000; i++) begin
      a     = norm_t'($urandom());
      exp_v = norm_ref(a);
      tick();
      n_checks++;
      if (y !== exp_v) begin
        n_fail++;
        $display("FAIL random[%0d]: A=%h out=%h expected=%h", i, a, y, exp_v);
      end else
        $display("random[%0d]: A=%h out=%h", i, a, y);
      if (y != 0) begin
        n_checks++;
        if (y[NORM_WIDTH] === y[NORM_WIDTH-1]) begin
          n_fail++;
          $display("FAIL random_sign[%0d]: out=%h top bits equal, expected differing", i, y);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    a        = 'x;
    test_reset();
    test_basic();
    test_hold();
    test_corners();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_normalizer
